// File: rtl/term_pkg.sv
// Shared types and character codes for the text-mode terminal video memory.
package term_pkg;

    typedef enum logic [1:0] {
        CLEAR      = 2'd0,
        IDLE       = 2'd1,
        SCROLL_CLR = 2'd2
    } state_t;

    localparam logic [7:0] SPACE    = 8'h20;
    localparam logic [7:0] BS       = 8'h08;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= PRINT_LO) && (code <= PRINT_HI);
    endfunction

endpackage

// File: rtl/term_ram.sv
// Character store: one synchronous write port, one synchronous read-first read port.
module term_ram
    import term_pkg::*;
#(
    parameter int DEPTH = 2100,
    parameter int AW    = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [DEPTH];

    // Write port; the array itself is never reset, the clear sweep fills it.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port; sees the pre-write contents when both ports hit the same cell.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= SPACE;
        end else begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/term_vmem.sv
// Terminal character buffer: cursor/key handling, circular-row scrolling,
// clear sweeps and an aligned display read port with cursor overlay.
module term_vmem
    import term_pkg::*;
#(
    parameter int COLS      = 70,
    parameter int ROWS      = 30,
    parameter int CHAR_H    = 16,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [7:0]                key_in,
    input  logic                      key_valid,
    output logic                      key_ready,
    input  logic [$clog2(COLS)-1:0]   x,
    input  logic [$clog2(ROWS)-1:0]   y,
    input  logic [9:0]                v_addr,
    output logic [7:0]                ascii_out,
    output logic [$clog2(CHAR_H)-1:0] row,
    output logic                      cursor_on,
    output logic [$clog2(COLS)-1:0]   cursor_x,
    output logic [$clog2(ROWS)-1:0]   cursor_y
);

    localparam int XW    = $clog2(COLS);
    localparam int YW    = $clog2(ROWS);
    localparam int RW    = $clog2(CHAR_H);
    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_t          state_r, state_s;
    logic [AW-1:0]   sweep_r, sweep_s;
    logic [YW-1:0]   top_r, top_s;
    logic [XW-1:0]   cur_x_r, cur_x_s;
    logic [YW-1:0]   cur_y_r, cur_y_s;
    logic            key_ready_r;
    logic [BW-1:0]   blink_cnt_r;
    logic            blink_r;
    logic [XW-1:0]   x_r;
    logic [YW-1:0]   y_r;
    logic [RW-1:0]   row_r;

    logic            we_s;
    logic [7:0]      wdata_s;
    logic [XW-1:0]   wcol_s;
    logic [YW-1:0]   wrow_s;
    logic [AW-1:0]   waddr_s;
    logic [AW-1:0]   raddr_s;
    logic            next_line_s;
    logic            unused_vaddr_s;

    // Logical row to physical row through the circular top pointer.
    function automatic logic [YW-1:0] phys_row(input logic [YW-1:0] lrow,
                                               input logic [YW-1:0] top);
        logic [YW:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        return (sum >= (YW+1)'(ROWS)) ? YW'(sum - (YW+1)'(ROWS)) : YW'(sum);
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] prow,
                                                input logic [XW-1:0] col);
        return AW'(prow) * AW'(COLS) + AW'(col);
    endfunction

    assign raddr_s        = cell_addr(phys_row(y, top_r), x);
    assign unused_vaddr_s = ^v_addr[9:RW];

    // Next-state, cursor and write-port decode.
    always_comb begin
        state_s     = state_r;
        sweep_s     = sweep_r;
        top_s       = top_r;
        cur_x_s     = cur_x_r;
        cur_y_s     = cur_y_r;
        we_s        = 1'b0;
        wdata_s     = SPACE;
        wcol_s      = cur_x_r;
        wrow_s      = cur_y_r;
        next_line_s = 1'b0;
        case (state_r)
            CLEAR: begin
                we_s = 1'b1;
                if (sweep_r == AW'(DEPTH - 1)) begin
                    state_s = IDLE;
                    sweep_s = AW'(0);
                end else begin
                    sweep_s = sweep_r + AW'(1);
                end
            end
            SCROLL_CLR: begin
                // cur_y_r sits on the bottom logical row; top_r is already advanced
                we_s   = 1'b1;
                wcol_s = sweep_r[XW-1:0];
                if (sweep_r == AW'(COLS - 1)) begin
                    state_s = IDLE;
                    sweep_s = AW'(0);
                end else begin
                    sweep_s = sweep_r + AW'(1);
                end
            end
            IDLE: begin
                if (!key_valid) begin
                    state_s = IDLE;
                end else if (is_printable(key_in)) begin
                    we_s    = 1'b1;
                    wdata_s = key_in;
                    if (cur_x_r < XW'(COLS - 1)) begin
                        cur_x_s = cur_x_r + XW'(1);
                    end else begin
                        cur_x_s     = XW'(0);
                        next_line_s = 1'b1;
                    end
                end else if ((key_in == LF) || (key_in == CR)) begin
                    cur_x_s     = XW'(0);
                    next_line_s = 1'b1;
                end else if (key_in == BS) begin
                    if (cur_x_r != XW'(0)) begin
                        cur_x_s = cur_x_r - XW'(1);
                        wcol_s  = cur_x_r - XW'(1);
                        we_s    = 1'b1;
                    end else if (cur_y_r != YW'(0)) begin
                        cur_x_s = XW'(COLS - 1);
                        cur_y_s = cur_y_r - YW'(1);
                        wcol_s  = XW'(COLS - 1);
                        wrow_s  = cur_y_r - YW'(1);
                        we_s    = 1'b1;
                    end else begin
                        we_s = 1'b0;
                    end
                end else begin
                    we_s = 1'b0;
                end
            end
            default: begin
                state_s = CLEAR;
                sweep_s = AW'(0);
            end
        endcase

        if (next_line_s && (cur_y_r < YW'(ROWS - 1))) begin
            cur_y_s = cur_y_r + YW'(1);
        end else if (next_line_s) begin
            top_s   = (top_r == YW'(ROWS - 1)) ? YW'(0) : top_r + YW'(1);
            state_s = SCROLL_CLR;
            sweep_s = AW'(0);
        end else begin
            top_s = top_r;
        end

        if (state_r == CLEAR) begin
            waddr_s = sweep_r;
        end else begin
            waddr_s = cell_addr(phys_row(wrow_s, top_r), wcol_s);
        end
    end

    // Control state, cursor and scroll pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= CLEAR;
            sweep_r     <= AW'(0);
            top_r       <= YW'(0);
            cur_x_r     <= XW'(0);
            cur_y_r     <= YW'(0);
            key_ready_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            sweep_r     <= sweep_s;
            top_r       <= top_s;
            cur_x_r     <= cur_x_s;
            cur_y_r     <= cur_y_s;
            key_ready_r <= (state_s == IDLE);
        end
    end

    // Cursor blink phase generator.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_r <= BW'(0);
            blink_r     <= 1'b0;
        end else if (blink_cnt_r == BW'(BLINK_DIV - 1)) begin
            blink_cnt_r <= BW'(0);
            blink_r     <= ~blink_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BW'(1);
        end
    end

    // Fetch coordinates and font row, delayed to line up with the RAM output.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_r   <= XW'(0);
            y_r   <= YW'(0);
            row_r <= RW'(0);
        end else begin
            x_r   <= x;
            y_r   <= y;
            row_r <= v_addr[RW-1:0];
        end
    end

    term_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clock(clock),
        .reset(reset),
        .we   (we_s),
        .waddr(waddr_s),
        .wdata(wdata_s),
        .raddr(raddr_s),
        .rdata(ascii_out)
    );

    assign key_ready = key_ready_r;
    assign row       = row_r;
    assign cursor_on = blink_r && (x_r == cur_x_r) && (y_r == cur_y_r);
    assign cursor_x  = cur_x_r;
    assign cursor_y  = cur_y_r;

endmodule

// File: tb/tb_term_vmem.sv
// Scoreboard bench for term_vmem against a logical-screen model with row shifting.
module tb_term_vmem;

    localparam int COLS      = 70;
    localparam int ROWS      = 30;
    localparam int CHAR_H    = 16;
    localparam int BLINK_DIV = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] key_in = 8'h00;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [6:0] x = 7'd0;
    logic [4:0] y = 5'd0;
    logic [9:0] v_addr = 10'd0;
    logic [7:0] ascii_out;
    logic [3:0] row;
    logic       cursor_on;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;

    typedef struct packed {
        logic [7:0] ch;
        logic [3:0] rw;
    } rd_t;

    rd_t        exp_q[$];
    logic [7:0] screen [ROWS][COLS];
    int         mx, my;
    int         n_checks = 0;
    int         n_errors = 0;

    term_vmem #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_H(CHAR_H), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clock(clock), .reset(reset), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .x(x), .y(y), .v_addr(v_addr),
        .ascii_out(ascii_out), .row(row), .cursor_on(cursor_on),
        .cursor_x(cursor_x), .cursor_y(cursor_y)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                screen[r][c] = 8'h20;
        mx = 0;
        my = 0;
    endtask

    task automatic model_key(input logic [7:0] k, output bit scrolled);
        bit nl;
        nl = 1'b0;
        scrolled = 1'b0;
        if (k >= 8'h20 && k <= 8'h7E) begin
            screen[my][mx] = k;
            if (mx < COLS - 1) mx++;
            else begin mx = 0; nl = 1'b1; end
        end else if (k == 8'h0A || k == 8'h0D) begin
            mx = 0;
            nl = 1'b1;
        end else if (k == 8'h08) begin
            if (mx > 0) begin
                mx--;
                screen[my][mx] = 8'h20;
            end else if (my > 0) begin
                mx = COLS - 1;
                my--;
                screen[my][mx] = 8'h20;
            end
        end
        if (nl) begin
            if (my < ROWS - 1) my++;
            else begin
                for (int r = 0; r < ROWS - 1; r++)
                    for (int c = 0; c < COLS; c++)
                        screen[r][c] = screen[r+1][c];
                for (int c = 0; c < COLS; c++)
                    screen[ROWS-1][c] = 8'h20;
                scrolled = 1'b1;
            end
        end
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_cx"}, cursor_x, mx);
        check({tag, "_cy"}, cursor_y, my);
    endtask

    task automatic wait_ready(input int expect_cycles, input string tag);
        int cnt;
        cnt = 0;
        while (!key_ready && cnt < 5000) begin
            cnt++;
            @(negedge clock);
        end
        check(tag, cnt, expect_cycles);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        key_valid = 1'b0;
        @(negedge clock);
        check("rst_ready", key_ready, 0);
        check("rst_ascii", ascii_out, 8'h20);
        check("rst_row", row, 0);
        check("rst_curon", cursor_on, 0);
        model_reset();
        check_cursor("rst");
        reset = 1'b0;
    endtask

    task automatic send_key(input logic [7:0] k);
        bit sc;
        @(negedge clock);
        key_in = k;
        key_valid = 1'b1;
        model_key(k, sc);
        @(negedge clock);
        key_valid = 1'b0;
        if (sc) wait_ready(COLS, "scroll_busy");
        check_cursor("key");
    endtask

    task automatic drop_key(input logic [7:0] k);
        @(negedge clock);
        key_in = k;
        key_valid = 1'b1;
        @(negedge clock);
        key_valid = 1'b0;
    endtask

    task automatic compare_out();
        rd_t e;
        e = exp_q.pop_front();
        check("ascii", ascii_out, e.ch);
        check("row", row, e.rw);
    endtask

    task automatic drive_fetch(input int xx, input int yy);
        logic [9:0] va;
        va = 10'($urandom_range(0, 1023));
        x = 7'(xx);
        y = 5'(yy);
        v_addr = va;
        exp_q.push_back('{ch: screen[yy][xx], rw: va[3:0]});
    endtask

    task automatic fetch(input int xx, input int yy);
        @(negedge clock);
        drive_fetch(xx, yy);
        @(negedge clock);
        compare_out();
    endtask

    task automatic scan_screen();
        for (int yy = 0; yy < ROWS; yy++)
            for (int xx = 0; xx < COLS; xx++) begin
                @(negedge clock);
                if (exp_q.size() > 0) compare_out();
                drive_fetch(xx, yy);
            end
        @(negedge clock);
        compare_out();
    endtask

    task automatic blink_check();
        int cnt;
        @(negedge clock);
        x = 7'(mx);
        y = 5'(my);
        @(negedge clock);
        cnt = 0;
        repeat (2 * BLINK_DIV) begin
            @(negedge clock);
            cnt += int'(cursor_on);
        end
        check("blink_on_cell", cnt, BLINK_DIV);
        x = 7'((mx + 1) % COLS);
        @(negedge clock);
        cnt = 0;
        repeat (2 * BLINK_DIV) begin
            @(negedge clock);
            cnt += int'(cursor_on);
        end
        check("blink_off_cell", cnt, 0);
    endtask

    initial begin
        bit sc;
        rd_t e;

        // Power-up clear
        model_reset();
        do_reset();
        wait_ready(ROWS * COLS, "clear_len");
        check_cursor("after_clear");
        scan_screen();

        // Printable key, with a same-cycle fetch of the written cell (read-first)
        @(negedge clock);
        x = 7'(mx);
        y = 5'(my);
        v_addr = 10'd37;
        exp_q.push_back('{ch: screen[my][mx], rw: 4'd5});
        key_in = 8'h41;
        key_valid = 1'b1;
        model_key(8'h41, sc);
        @(negedge clock);
        key_valid = 1'b0;
        compare_out();
        check_cursor("key_a");
        fetch(0, 0);
        send_key(8'h1B);
        fetch(1, 0);
        blink_check();

        // Line wrap after a full row
        do_reset();
        wait_ready(ROWS * COLS, "clear_len2");
        for (int i = 0; i < COLS; i++) begin
            @(negedge clock);
            key_in = 8'(8'h61 + (i % 26));
            key_valid = 1'b1;
            model_key(key_in, sc);
            @(negedge clock);
            key_valid = 1'b0;
        end
        check_cursor("wrap");
        send_key(8'h42);
        fetch(0, 1);
        fetch(COLS - 1, 0);

        // Backspace across the line boundary, carriage return, no-op at origin
        send_key(8'h08);
        send_key(8'h08);
        fetch(COLS - 1, 0);
        fetch(0, 1);
        send_key(8'h0D);
        do_reset();
        wait_ready(ROWS * COLS, "clear_len3");
        repeat (3) send_key(8'h08);
        scan_screen();

        // Scroll at the bottom row, then a full wrap of the top pointer
        send_key(8'h0A);
        send_key(8'h5A);
        repeat (ROWS - 2) send_key(8'h0A);
        for (int i = 0; i < 5; i++) send_key(8'(8'h30 + i));
        check_cursor("pre_scroll");
        send_key(8'h0A);
        @(negedge clock);
        x = 7'd0;
        y = 5'd0;
        @(negedge clock);
        check("scroll_z", ascii_out, 8'h5A);
        scan_screen();
        send_key(8'h51);
        repeat (ROWS) send_key(8'h0A);
        scan_screen();
        blink_check();

        // Reset during the scroll clear; keys while busy are dropped
        @(negedge clock);
        key_in = 8'h0A;
        key_valid = 1'b1;
        @(negedge clock);
        key_valid = 1'b0;
        repeat (10) @(negedge clock);
        check("busy_in_scroll", key_ready, 0);
        drop_key(8'h4D);
        do_reset();
        wait_ready(ROWS * COLS, "clear_after_scroll_rst");
        check_cursor("after_scroll_rst");
        scan_screen();
        send_key(8'h51);
        fetch(0, 0);

        // Reset during the clear sweep right after a dropped key
        do_reset();
        drop_key(8'h58);
        drop_key(8'h0A);
        check_cursor("drop_in_clear");
        repeat (7) @(negedge clock);
        do_reset();
        wait_ready(ROWS * COLS, "clear_restart");
        check_cursor("after_restart");
        scan_screen();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/term_vmem.md
Name: term_vmem

Overview:
Parametrised character buffer for the text-mode VGA terminal; successor to the fixed-size video memory between the PS/2 decoder and the font ROM / VGA timing path. It accepts ASCII codes from the keyboard path and maintains a cursor with line wrap, newline and backspace handling. It hardware-scrolls through a circular top-row pointer and serves the display read port with aligned font-row and cursor-overlay outputs. A full-screen clear sweep runs after reset.

Parameters:
COLS, 70, characters per line
ROWS, 30, lines per screen
CHAR_H, 16, font rows per character cell (power of two)
BLINK_DIV, 25000000, clock cycles per cursor blink phase

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
key_in  in  8  ASCII code from keyboard path
key_valid  in  1  one-cycle strobe qualifying key_in
key_ready  out  1  high when a key can be accepted (IDLE)
x  in  $clog2(COLS)  display column being fetched
y  in  $clog2(ROWS)  display (logical) row being fetched
v_addr  in  10  current VGA line
ascii_out  out  8  character at (x,y), 1-cycle latency
row  out  $clog2(CHAR_H)  v_addr mod CHAR_H, registered, aligned with ascii_out
cursor_on  out  1  fetched cell is the cursor cell and blink phase is high, aligned with ascii_out
cursor_x  out  $clog2(COLS)  current cursor column
cursor_y  out  $clog2(ROWS)  current cursor logical row

Behaviour:
- Reset (synchronous, active-high, one clock): state=CLEAR, sweep address=0, top=0, cursor=(0,0), blink counter and phase=0. ascii_out=0x20, row=0, cursor_on=0, key_ready=0.
- Physical row = (logical row + top) mod ROWS. This mapping applies to both the read port and writes. Modulo is by compare-and-subtract, never a divider.
- CLEAR: writes 0x20 to one physical cell per cycle over all ROWS*COLS cells, then goes to IDLE. Duration is ROWS*COLS cycles.
- IDLE (key_ready=1): on key_valid, decode key_in:
  - 0x20..0x7E: write at cursor. If cursor_x<COLS-1, cursor_x++. Otherwise cursor_x=0 and do NEXT_LINE.
  - 0x0A or 0x0D: cursor_x=0, then NEXT_LINE. No cell write.
  - 0x08: if cursor_x>0, cursor_x-- and write 0x20 at the new position. If cursor_x=0 and cursor_y>0, cursor moves to (COLS-1, cursor_y-1) and that cell is written 0x20. At (0,0) the key is a no-op.
  - Any other code: ignored.
  - Write and cursor update complete in the accepting cycle; state stays IDLE.
- NEXT_LINE: if cursor_y<ROWS-1, cursor_y++. Otherwise top=(top+1) mod ROWS, cursor_y stays ROWS-1, and state goes to SCROLL_CLR.
- SCROLL_CLR (key_ready=0): writes 0x20 to the COLS cells of the new bottom physical row, one per cycle, then returns to IDLE.
- key_valid while key_ready=0 is dropped. The source must hold off; no queueing.
- Read port is always active, including during CLEAR and SCROLL_CLR. It shows in-progress content.
- Read and write to the same cell in the same cycle: the read returns the old data (read-first).
- Blink: counter wraps at BLINK_DIV-1 and toggles the phase. cursor_on compares the registered (x,y) against the cursor.
- Reset asserted in any state, including mid-sweep or mid-scroll, restarts CLEAR from address 0. Partially cleared content is discarded.

Decomposition:
- Package term_pkg:
  - state enum {CLEAR, IDLE, SCROLL_CLR}
  - ASCII constants: SPACE=0x20, BS=0x08, LF=0x0A, CR=0x0D, PRINT_LO=0x20, PRINT_HI=0x7E
- Sub-module term_ram: simple dual-port RAM of ROWS*COLS x 8 with one synchronous write port and one synchronous read-first read port. Address = phys_row*COLS + col.

Test Plan:
1. Reset, then release -> key_ready=0 for exactly 2100 cycles, then 1. Reading every (x,y) gives 0x20 one cycle later; cursor=(0,0).
2. key_in=0x41 strobed in IDLE -> next cycle cursor_x=1. Fetch (0,0) -> ascii_out=0x41 one cycle later; unprintable 0x1B -> no change.
3. 70 printable keys from (0,0), then 0x42 -> cursor (0,1) before 0x42. Cell (0,1)=0x42, cursor (1,1).
4. From (0,1): 0x08 -> cursor (69,0), cell (69,0)=0x20. Then 0x0D at (69,0) -> cursor (0,1). Then three BS at (0,0) after reset -> cursor stays (0,0), no writes.
5. Cursor at (5,29), row 1 holds 'Z' at col 0, 0x0A -> key_ready low for 70 cycles, top=1. Display y=0 x=0 reads 'Z', y=29 reads all 0x20, cursor (0,29).
6. Assert reset during SCROLL_CLR and during the first key in CLEAR -> both restart full 2100-cycle sweep with top=0 and cursor (0,0). Keys strobed while key_ready=0 leave no trace.
